// File: rtl/io_nibble_tx.sv
// Nibble-serial transmitter: FIFO-buffered words sent MSB nibble first over pin_o with a toggle STB/ack handshake.
// Optional feature: define PARITY_EN to drive even parity of each nibble on pin_o[4].
module io_nibble_tx #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             host_ack,
    output logic [7:0]       pin_o,
    output logic             busy,
    output logic             err
);

    localparam int NIB = WIDTH / 4;
    localparam int AW  = $clog2(DEPTH);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, ERROR} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic             ack_p0, ack_p1;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    nib_cnt;
    logic [TW-1:0]    timer;
    logic             ack_match, last_nib, tmo, par_bit;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_ready  = !full && (state != ERROR);
    assign push      = tx_valid && tx_ready;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;
    assign ack_match = (ack_p1 == pin_o[7]);
    assign last_nib  = (nib_cnt == LAST_NIB);
    assign tmo       = (timer == TMO_LAST);

`ifdef PARITY_EN
    assign par_bit = ^shift_reg[WIDTH-1 -: 4];
`else
    assign par_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
    end

    // host_ack is asynchronous: two-flop synchronizer, ack_p1 is the usable copy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_p0 <= 1'b0;
            ack_p1 <= 1'b0;
        end else begin
            ack_p0 <= host_ack;
            ack_p1 <= ack_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!empty) state_nxt = SEND;
            SEND:  state_nxt = WAIT;
            WAIT: begin
                if (ack_match) state_nxt = last_nib ? IDLE : SEND;
                else if (tmo)  state_nxt = ERROR;
            end
            ERROR: state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pop)
            shift_reg <= mem[rd_ptr[AW-1:0]];
        else if (state == WAIT && ack_match && !last_nib)
            shift_reg <= shift_reg << 4;
    end

    // All pin_o fields update together on the SEND edge; ERR is raised on the timeout edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pin_o   <= 8'h00;
            err     <= 1'b0;
            nib_cnt <= '0;
            timer   <= '0;
        end else begin
            case (state)
                IDLE: if (pop) nib_cnt <= '0;
                SEND: begin
                    pin_o <= {~pin_o[7], (nib_cnt == '0), pin_o[5], par_bit, shift_reg[WIDTH-1 -: 4]};
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (ack_match) begin
                        if (!last_nib) nib_cnt <= nib_cnt + 1'b1;
                    end else if (tmo) begin
                        err      <= 1'b1;
                        pin_o[5] <= 1'b1;
                    end
                end
                ERROR: begin
                    err      <= 1'b1;
                    pin_o[5] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_nibble_tx.sv
// Testbench for io_nibble_tx: directed steps plus randomized words against a nibble-stream reference model.
module tb_io_nibble_tx;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;
    localparam int NIB     = WIDTH / 4;
`ifdef PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] tx_data = '0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic             host_ack = 1'b0;
    logic [7:0]       pin_o;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stb_cyc = 0;
    logic [7:0]       got_q[$];
    logic [WIDTH-1:0] exp_w[$];
    bit host_en = 1'b0;
    int host_dly = 3;
    int kick_req = 0;

    io_nibble_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .host_ack(host_ack), .pin_o(pin_o), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Records every STB toggle seen while out of reset
    initial begin
        logic last_stb;
        last_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && pin_o[7] !== last_stb) begin
                got_q.push_back(pin_o);
                stb_cyc = cyc;
            end
            last_stb = pin_o[7];
        end
    end

    // Host: echoes STB after a delay; a kick request forces a spurious ack toggle
    initial begin
        int hcnt, kick_done, dly;
        hcnt = 0; kick_done = 0; dly = 3;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                host_ack = 1'b0;
                hcnt = 0;
            end else if (kick_req != kick_done) begin
                host_ack = ~host_ack;
                kick_done = kick_req;
            end else if (host_en && host_ack !== pin_o[7]) begin
                if (hcnt == 0) dly = (host_dly == 0) ? int'($urandom_range(5, 1)) : host_dly;
                hcnt++;
                if (hcnt >= dly) begin
                    host_ack = pin_o[7];
                    hcnt = 0;
                end
            end else begin
                hcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input int n);
        tx_valid = 1'b0;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_word(input logic [WIDTH-1:0] w);
        int n;
        n = 0;
        while (!tx_ready && n < 1000) begin
            tick(1);
            n++;
        end
        if (!tx_ready) chk("write_ready_wait", 32'(tx_ready), 32'd1);
        tx_data = w;
        tx_valid = 1'b1;
        if (tx_ready) exp_w.push_back(w);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Reference: each word yields NIB nibbles MSB first; STB alternates starting at 1 after reset
    task automatic check_stream(input int base, input string tag);
        int n_exp, n_got;
        n_exp = exp_w.size() * NIB;
        n_got = got_q.size() - base;
        chk({tag, "_count"}, 32'(n_got), 32'(n_exp));
        for (int k = 0; k < n_exp && k < n_got; k++) begin
            logic [WIDTH-1:0] w;
            logic [3:0] nib;
            logic [7:0] expv;
            int i;
            w = exp_w[k / NIB];
            i = k % NIB;
            nib = w[4*(NIB-1-i) +: 4];
            expv = {(k % 2 == 0), (i == 0), 1'b0, (PAR_ON ? ^nib : 1'b0), nib};
            chk($sformatf("%s_nib%0d", tag, k), 32'(got_q[base + k]), 32'(expv));
        end
    endtask

    initial begin
        int base, acc, n;
        logic [WIDTH-1:0] w0;
        logic [3:0] pv;

        // Reset state
        do_reset(3);
        chk("rst_pin", 32'(pin_o), 32'h00);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Single word with echoing host, plus write-to-STB latency
        host_en = 1'b1; host_dly = 3;
        base = got_q.size(); exp_w.delete();
        write_word(16'hA5C3);
        @(negedge clk);
        @(negedge clk);
        chk("lat_e1_stb", 32'(pin_o[7]), 32'd0);
        @(negedge clk);
        chk("lat_e2_stb", 32'(pin_o[7]), 32'd1);
        chk("lat_e2_first", 32'(pin_o[6:0]), 32'h4A);
        wait_idle(300, "t1_idle");
        check_stream(base, "t1");
        chk("t1_err", 32'(err), 32'd0);

        // Parity pattern
        do_reset(2);
        base = got_q.size(); exp_w.delete();
        write_word(16'h7F01);
        wait_idle(300, "t4_idle");
        check_stream(base, "t4");
        if (got_q.size() >= base + 4) begin
            pv = {got_q[base][4], got_q[base+1][4], got_q[base+2][4], got_q[base+3][4]};
            chk("t4_par", 32'(pv), PAR_ON ? 32'h9 : 32'h0);
        end

        // Randomized words and gaps with random host latency
        do_reset(2);
        host_dly = 0;
        base = got_q.size(); exp_w.delete();
        for (int i = 0; i < 24; i++) begin
            tick($urandom_range(2, 0));
            write_word(WIDTH'($urandom));
        end
        wait_idle(4000, "t6_idle");
        check_stream(base, "t6");
        chk("t6_err", 32'(err), 32'd0);

        // Stalled host: DEPTH+1 words accepted
        do_reset(2);
        host_en = 1'b0; host_dly = 3;
        acc = 0; w0 = '0;
        for (int i = 0; i < 6; i++) begin
            tx_data = WIDTH'($urandom);
            tx_valid = 1'b1;
            if (tx_ready) begin
                acc++;
                if (acc == 1) w0 = tx_data;
            end
            tick(1);
        end
        tx_valid = 1'b0;
        chk("t2_accepted", 32'(acc), 32'(DEPTH + 1));
        chk("t2_ready", 32'(tx_ready), 32'd0);
        chk("t2_pin", 32'(pin_o), 32'({2'b11, 1'b0, (PAR_ON ? ^w0[WIDTH-1 -: 4] : 1'b0), w0[WIDTH-1 -: 4]}));
        chk("t2_busy", 32'(busy), 32'd1);

        // Timeout exactly TIMEOUT cycles after entering WAIT
        while (cyc < stb_cyc + TIMEOUT - 1) @(negedge clk);
        chk("t3_err_before", 32'(err), 32'd0);
        @(negedge clk);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_pin", 32'(pin_o), 32'({2'b11, 1'b1, (PAR_ON ? ^w0[WIDTH-1 -: 4] : 1'b0), w0[WIDTH-1 -: 4]}));
        chk("t3_ready", 32'(tx_ready), 32'd0);
        kick_req++;
        repeat (10) @(negedge clk);
        chk("t3_err_sticky", 32'(err), 32'd1);
        chk("t3_pin_hold", 32'(pin_o), 32'({2'b11, 1'b1, (PAR_ON ? ^w0[WIDTH-1 -: 4] : 1'b0), w0[WIDTH-1 -: 4]}));

        // Reset during the second nibble with words queued
        do_reset(2);
        chk("t5_err_clear", 32'(err), 32'd0);
        host_en = 1'b1; host_dly = 3;
        base = got_q.size(); exp_w.delete();
        for (int i = 0; i < 3; i++) write_word(WIDTH'($urandom));
        n = 0;
        while (got_q.size() < base + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t5_second_nib", 32'(got_q.size() - base), 32'd2);
        #1;
        do_reset(1);
        chk("t5_pin", 32'(pin_o), 32'h00);
        chk("t5_ready", 32'(tx_ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("t5_no_stb", 32'(got_q.size() - base), 32'd2);
        chk("t5_busy_after", 32'(busy), 32'd0);
        chk("t5_pin_after", 32'(pin_o), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
